// File: rtl/dis_pipe_array.sv
// Pipe-sprite renderer for up to NUM_PIPES pipe pairs (upper and lower head-and-body pipes).
// Takes the pixel being painted and returns a paint enable, an RGB565 colour and the index of
// the pipe that drew it, exactly 4 cycles later. One new pixel is accepted every cycle.
// Pipe geometry is latched into shadow registers on frame_start, so that game-logic updates
// never tear mid-frame.
//
// Sprite images are packed parameters, with entry 0 in the least significant bits:
//   HEAD_IMG : HEAD_W*HEAD_H 4-bit palette indices, row-major
//   BODY_IMG : HEAD_W 4-bit palette indices (one body row, repeated vertically)
//   PAL_IMG  : 16 RGB565 colours; palette index 0 is transparent
//
// Ports:
//   clk, rstn        clock; synchronous active-low reset
//   i_frame_start    one-cycle pulse that latches i_pos_x, i_gap_y and i_pipe_en
//   i_pos_x          signed left edge of pipe i at bits [16i+15:16i]
//   i_gap_y          signed top row of the gap of pipe i
//   i_pipe_en        per-pipe visibility mask
//   i_paint_x/y      signed pixel column / row being painted
//   o_paint_enable   pixel is opaque pipe
//   o_paint_color    RGB565 colour (don't-care while o_paint_enable is 0)
//   o_paint_pipe     index of the pipe that drew the pixel
module dis_pipe_array #(
   parameter int unsigned                NUM_PIPES   = 3,
   parameter int unsigned                SCALE_SHIFT = 2,
   parameter int unsigned                HEAD_W      = 26,
   parameter int unsigned                HEAD_H      = 12,
   parameter int unsigned                GAP_H       = 208,
   parameter int unsigned                GROUND_Y    = 400,
   parameter logic [4*HEAD_W*HEAD_H-1:0] HEAD_IMG    = '0,
   parameter logic [4*HEAD_W-1:0]        BODY_IMG    = '0,
   parameter logic [16*16-1:0]           PAL_IMG     = '0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_frame_start,
   input  logic [16*NUM_PIPES-1:0] i_pos_x,
   input  logic [16*NUM_PIPES-1:0] i_gap_y,
   input  logic [NUM_PIPES-1:0]    i_pipe_en,
   input  logic [15:0]             i_paint_x,
   input  logic [15:0]             i_paint_y,
   output logic                    o_paint_enable,
   output logic [15:0]             o_paint_color,
   output logic [2:0]              o_paint_pipe
);

   localparam int unsigned PW   = HEAD_W << SCALE_SHIFT;
   localparam int unsigned PH   = HEAD_H << SCALE_SHIFT;
   localparam int unsigned DX_W = $clog2(PW);
   localparam int unsigned HY_W = $clog2(PH);
   localparam int unsigned HA_W = $clog2(HEAD_W * HEAD_H);
   localparam int unsigned BA_W = $clog2(HEAD_W);

   localparam logic signed [16:0] C_PW     = 17'(PW);
   localparam logic signed [17:0] C_PH     = 18'(PH);
   localparam logic signed [17:0] C_GAP    = 18'(GAP_H);
   localparam logic signed [17:0] C_GROUND = 18'(GROUND_Y);

   typedef enum logic [1:0] {RegNone, RegHead, RegBody} region_e;

   // ROM images unpacked into addressable arrays
   logic [3:0]  w_head_rom [HEAD_W*HEAD_H];
   logic [3:0]  w_body_rom [HEAD_W];
   logic [15:0] w_pal_rom  [16];

   for (genvar a = 0; a < HEAD_W * HEAD_H; a++) begin : g_head_rom
      assign w_head_rom[a] = HEAD_IMG[4*a +: 4];
   end
   for (genvar a = 0; a < HEAD_W; a++) begin : g_body_rom
      assign w_body_rom[a] = BODY_IMG[4*a +: 4];
   end
   for (genvar a = 0; a < 16; a++) begin : g_pal_rom
      assign w_pal_rom[a] = PAL_IMG[16*a +: 16];
   end

   // Shadow registers: the geometry below only ever sees these
   logic [15:0]          r_pos_x [NUM_PIPES];
   logic [15:0]          r_gap_y [NUM_PIPES];
   logic [NUM_PIPES-1:0] r_pipe_en;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < int'(NUM_PIPES); i++) begin
            r_pos_x[i] <= '0;
            r_gap_y[i] <= '0;
         end
         r_pipe_en <= '0;
      end else if (i_frame_start) begin
         for (int i = 0; i < int'(NUM_PIPES); i++) begin
            r_pos_x[i] <= i_pos_x[16*i +: 16];
            r_gap_y[i] <= i_gap_y[16*i +: 16];
         end
         r_pipe_en <= i_pipe_en;
      end
   end

   // Per-pipe geometry, widened so that no subtraction or offset can wrap
   logic signed [17:0]   w_py;
   logic                 w_row_ok;
   logic [NUM_PIPES-1:0] w_hit_head;
   logic [NUM_PIPES-1:0] w_hit_body;
   logic [DX_W-1:0]      w_dx_p [NUM_PIPES];
   logic [HY_W-1:0]      w_hy_p [NUM_PIPES];

   assign w_py     = {{2{i_paint_y[15]}}, i_paint_y};
   assign w_row_ok = !w_py[17] && (w_py < C_GROUND);

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_geo
      logic signed [16:0] w_dx;
      logic signed [17:0] w_gy;
      logic signed [17:0] w_uh_top;
      logic signed [17:0] w_lh_top;
      logic signed [17:0] w_lb_top;
      logic               w_col;
      logic               w_ub;
      logic               w_uh;
      logic               w_lh;
      logic               w_lb;

      assign w_dx     = {i_paint_x[15], i_paint_x} - {r_pos_x[g][15], r_pos_x[g]};
      assign w_gy     = {{2{r_gap_y[g][15]}}, r_gap_y[g]};
      assign w_uh_top = w_gy - C_PH;
      assign w_lh_top = w_gy + C_GAP;
      assign w_lb_top = w_lh_top + C_PH;

      assign w_col = !w_dx[16] && (w_dx < C_PW);
      assign w_ub  = w_py < w_uh_top;
      assign w_uh  = (w_py >= w_uh_top) && (w_py < w_gy);
      assign w_lh  = (w_py >= w_lh_top) && (w_py < w_lb_top);
      assign w_lb  = w_py >= w_lb_top;

      assign w_hit_head[g] = w_col && w_row_ok && (w_uh || w_lh);
      assign w_hit_body[g] = w_col && w_row_ok && (w_ub || w_lb);
      assign w_dx_p[g]     = w_dx[DX_W-1:0];
      // Upper head is drawn upside down: its bottom row is head row 0
      assign w_hy_p[g]     = w_uh ? HY_W'(w_gy - w_py - 18'sd1) : HY_W'(w_py - w_lh_top);
   end

   // S1: pick the winning pipe
   region_e         w_s1_type;
   logic [2:0]      w_s1_pipe;
   logic [DX_W-1:0] w_s1_dx;
   logic [HY_W-1:0] w_s1_hy;

   always_comb begin
      w_s1_type = RegNone;
      w_s1_pipe = '0;
      w_s1_dx   = '0;
      w_s1_hy   = '0;
      // Walk downwards so the lowest-index hit is the one left standing
      for (int i = int'(NUM_PIPES) - 1; i >= 0; i--) begin
         if (r_pipe_en[i] && (w_hit_head[i] || w_hit_body[i])) begin
            w_s1_type = w_hit_head[i] ? RegHead : RegBody;
            w_s1_pipe = 3'(i);
            w_s1_dx   = w_dx_p[i];
            w_s1_hy   = w_hy_p[i];
         end
      end
   end

   region_e         r_s1_type;
   logic [2:0]      r_s1_pipe;
   logic [DX_W-1:0] r_s1_dx;
   logic [HY_W-1:0] r_s1_hy;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_s1_type <= RegNone;
         r_s1_pipe <= '0;
         r_s1_dx   <= '0;
         r_s1_hy   <= '0;
      end else begin
         r_s1_type <= w_s1_type;
         r_s1_pipe <= w_s1_pipe;
         r_s1_dx   <= w_s1_dx;
         r_s1_hy   <= w_s1_hy;
      end
   end

   // S2: bitmap address
   logic [HY_W-1:0] w_brow;
   logic [DX_W-1:0] w_bcol;
   logic [HA_W-1:0] w_s2_addr;

   assign w_brow    = r_s1_hy >> SCALE_SHIFT;
   assign w_bcol    = r_s1_dx >> SCALE_SHIFT;
   assign w_s2_addr = (r_s1_type == RegHead) ?
                      HA_W'(int'(w_brow) * int'(HEAD_W) + int'(w_bcol)) : HA_W'(w_bcol);

   region_e         r_s2_type;
   logic [2:0]      r_s2_pipe;
   logic [HA_W-1:0] r_s2_addr;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_s2_type <= RegNone;
         r_s2_pipe <= '0;
         r_s2_addr <= '0;
      end else begin
         r_s2_type <= r_s1_type;
         r_s2_pipe <= r_s1_pipe;
         r_s2_addr <= w_s2_addr;
      end
   end

   // S3: head/body ROM read
   logic       r_s3_valid;
   logic [2:0] r_s3_pipe;
   logic [3:0] r_s3_pix;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_s3_valid <= 1'b0;
         r_s3_pipe  <= '0;
         r_s3_pix   <= '0;
      end else begin
         r_s3_valid <= (r_s2_type != RegNone);
         r_s3_pipe  <= r_s2_pipe;
         case (r_s2_type)
            RegHead: r_s3_pix <= w_head_rom[r_s2_addr];
            RegBody: r_s3_pix <= w_body_rom[r_s2_addr[BA_W-1:0]];
            default: r_s3_pix <= '0;
         endcase
      end
   end

   // S4: palette read; index 0 is transparent
   logic        r_en;
   logic [2:0]  r_pipe;
   logic [15:0] r_color;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_en   <= 1'b0;
         r_pipe <= '0;
      end else begin
         r_en   <= r_s3_valid && (r_s3_pix != 4'd0);
         r_pipe <= r_s3_pipe;
      end
   end

   always_ff @(posedge clk) begin
      r_color <= w_pal_rom[r_s3_pix];
   end

   assign o_paint_enable = r_en;
   assign o_paint_color  = r_color;
   assign o_paint_pipe   = r_pipe;

endmodule
